// File: rtl/ibufds_tap_calib.sv
`default_nettype none
// ============================================================================
//  Module      : ibufds_tap_calib
//  Description : Per-lane input delay calibration for an
//                IBUFDS -> IDELAY -> ISERDES path. Sweeps every delay tap,
//                qualifies each tap against a fixed training word, tracks the
//                longest contiguous run of passing taps and finally loads the
//                centre of that run into the delay line.
//  Ports       : CLK        clock
//                RST        asynchronous active-high reset
//                START      one-cycle (re)calibration request
//                DLY_RDY    delay control ready; no load while low
//                DATA       deserialised word, valid every cycle
//                TAP_VALUE  tap value presented to the delay line
//                TAP_LD     one-cycle load strobe for TAP_VALUE
//                BUSY       calibration in progress
//                CAL_DONE   sticky, successful calibration
//                CAL_FAIL   sticky, no tap passed
//                TAP_MAP    per-tap pass map (IBUFDS_CALIB_STATS_EN only)
//  Options     : define IBUFDS_CALIB_STATS_EN to add the TAP_MAP output
//  Revision    : 1.0 - initial release
// ============================================================================
module ibufds_tap_calib #(
    parameter int            NTAPS   = 32,
    parameter int            TAP_W   = 5,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] PATTERN = 8'h5C,
    parameter int            SETTLE  = 16,
    parameter int            SAMPLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DLY_RDY,
    input  logic [DW-1:0]    DATA,
    output logic [TAP_W-1:0] TAP_VALUE,
    output logic             TAP_LD,
    output logic             BUSY,
    output logic             CAL_DONE,
    output logic             CAL_FAIL
`ifdef IBUFDS_CALIB_STATS_EN
    ,
    output logic [NTAPS-1:0] TAP_MAP
`endif
);

    // One extra bit on tap/run counters so NTAPS == 2**TAP_W cannot wrap.
    localparam int CW = TAP_W + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(SAMPLES + 1);

    localparam logic [CW-1:0] TAP_LAST     = CW'(NTAPS - 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
    localparam logic [MW-1:0] SAMPLES_LAST = MW'(SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_LOAD     = 3'd2,
        S_SETTLE   = 3'd3,
        S_CHECK    = 3'd4,
        S_NEXT     = 3'd5,
        S_FINAL    = 3'd6
    } state_t;

    state_t            state, state_next;
    logic              start_pend;   // forces the automatic run after reset
    logic [CW-1:0]     tap, run_len, run_start, best_len, best_start;
    logic [CW-1:0]     run_len_new, run_start_new;
    logic [SW-1:0]     settle_cnt;
    logic [MW-1:0]     match_cnt;
    logic              tap_pass;
    logic [TAP_W-1:0]  tap_value_q, final_value;
    logic              go, data_ok;

    assign go      = START | start_pend;
    assign data_ok = (DATA == PATTERN);

    // Run bookkeeping for the tap being retired in S_NEXT.
    assign run_len_new   = tap_pass ? run_len + 1'b1 : '0;
    assign run_start_new = (tap_pass && run_len == '0) ? tap : run_start;

    assign final_value = (best_len == '0) ? '0
                       : TAP_W'(best_start + ((best_len - 1'b1) >> 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (go) state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (DLY_RDY) state_next = S_LOAD;
            S_LOAD:     state_next = DLY_RDY ? S_SETTLE : S_WAIT_RDY;
            S_SETTLE: begin
                if (!DLY_RDY)                      state_next = S_WAIT_RDY;
                else if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
            end
            S_CHECK: begin
                // Losing DLY_RDY discards this tap; it is reloaded later.
                if (!DLY_RDY)                                   state_next = S_WAIT_RDY;
                else if (!data_ok || match_cnt == SAMPLES_LAST) state_next = S_NEXT;
            end
            S_NEXT:     state_next = (tap == TAP_LAST) ? S_FINAL : S_WAIT_RDY;
            S_FINAL:    if (DLY_RDY) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    assign BUSY   = (state != S_IDLE);
    assign TAP_LD = DLY_RDY && (state == S_LOAD || state == S_FINAL);

    always_comb begin
        TAP_VALUE = tap_value_q;
        if (state == S_LOAD)       TAP_VALUE = tap[TAP_W-1:0];
        else if (state == S_FINAL) TAP_VALUE = final_value;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_pend  <= 1'b1;
            tap         <= '0;
            run_len     <= '0;
            run_start   <= '0;
            best_len    <= '0;
            best_start  <= '0;
            settle_cnt  <= '0;
            match_cnt   <= '0;
            tap_pass    <= 1'b0;
            tap_value_q <= '0;
            CAL_DONE    <= 1'b0;
            CAL_FAIL    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    start_pend <= 1'b0;
                    CAL_DONE   <= 1'b0;
                    CAL_FAIL   <= 1'b0;
                    tap        <= '0;
                    run_len    <= '0;
                    run_start  <= '0;
                    best_len   <= '0;
                    best_start <= '0;
                end
                S_LOAD: if (DLY_RDY) begin
                    tap_value_q <= tap[TAP_W-1:0];
                    settle_cnt  <= '0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    match_cnt  <= '0;
                end
                S_CHECK: begin
                    // Holds the verdict of the last compared word, which is
                    // the tap verdict on the cycle CHECK is left.
                    tap_pass <= data_ok;
                    if (data_ok) match_cnt <= match_cnt + 1'b1;
                end
                S_NEXT: begin
                    run_len   <= run_len_new;
                    run_start <= run_start_new;
                    // Strictly greater: on a tie the earlier window wins.
                    if (run_len_new > best_len) begin
                        best_len   <= run_len_new;
                        best_start <= run_start_new;
                    end
                    if (tap != TAP_LAST) tap <= tap + 1'b1;
                end
                S_FINAL: if (DLY_RDY) begin
                    tap_value_q <= final_value;
                    if (best_len == '0) CAL_FAIL <= 1'b1;
                    else                CAL_DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IBUFDS_CALIB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                          TAP_MAP <= '0;
        else if (state == S_IDLE && go)   TAP_MAP <= '0;
        else if (state == S_NEXT && tap_pass)
            TAP_MAP <= TAP_MAP | (NTAPS'(1) << tap);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibufds_tap_calib.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibufds_tap_calib
//  Description : Scoreboard bench for ibufds_tap_calib. A behavioural delay
//                line returns the training word only while the loaded tap is
//                inside a per-test pass mask; expected calibration results
//                are queued by the stimulus and checked by a monitor when
//                BUSY falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibufds_tap_calib;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dly_rdy = 1'b1;
    logic [7:0]  data;
    logic [4:0]  tap_value;
    logic        tap_ld, busy, cal_done, cal_fail;
`ifdef IBUFDS_CALIB_STATS_EN
    logic [31:0] tap_map;
`endif

    always #5 clk = ~clk;

    ibufds_tap_calib dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .DLY_RDY   (dly_rdy),
        .DATA      (data),
        .TAP_VALUE (tap_value),
        .TAP_LD    (tap_ld),
        .BUSY      (busy),
        .CAL_DONE  (cal_done),
        .CAL_FAIL  (cal_fail)
`ifdef IBUFDS_CALIB_STATS_EN
        ,
        .TAP_MAP   (tap_map)
`endif
    );

    typedef struct {
        logic [4:0]  tv;
        logic        done;
        logic        fail;
        logic [31:0] map;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mask = '0;
    logic [4:0]  loaded_tap = '0;
    logic [4:0]  last_ld_val = '0;
    logic        prev_busy = 1'b0;
    logic        prev_ld = 1'b0;
    int          ld7_count = 0;

    // Behavioural delay line: the word seen depends on the loaded tap.
    assign data = mask[loaded_tap] ? 8'h5C : 8'hA3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tracks loads, enforces strobe rules, scores each completed run.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            prev_ld   = 1'b0;
        end else begin
            if (tap_ld) begin
                chk("tap_ld_rules", {30'd0, prev_ld, !dly_rdy}, 32'd0);
                loaded_tap  = tap_value;
                last_ld_val = tap_value;
                if (tap_value == 5'd7) ld7_count++;
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("final_ld_value", {27'd0, last_ld_val}, {27'd0, e.tv});
                    chk("tap_value", {27'd0, tap_value}, {27'd0, e.tv});
                    chk("cal_done", {31'd0, cal_done}, {31'd0, e.done});
                    chk("cal_fail", {31'd0, cal_fail}, {31'd0, e.fail});
`ifdef IBUFDS_CALIB_STATS_EN
                    chk("tap_map", tap_map, e.map);
`endif
                end
            end
            prev_busy = busy;
            prev_ld   = tap_ld;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic push(input logic [31:0] m, input logic [4:0] tv, input logic d, input logic f);
        exp_t e;
        e.tv = tv; e.done = d; e.fail = f; e.map = m;
        sb.push_back(e);
    endtask

    // Waits (bounded) until every queued result has been scored.
    task automatic wait_scored(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 8000) begin
            cyc(1);
            n++;
        end
        if (n >= 8000) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
        cyc(3);
    endtask

    task automatic wait_load(input logic [4:0] v, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 8000 && !ok) begin
            @(negedge clk);
            if (tap_ld && tap_value == v) ok = 1'b1;
            n++;
        end
    endtask

    initial begin
        bit ok;
        // Reset state
        cyc(3);
        chk("rst_tap_value", {27'd0, tap_value}, 32'd0);
        chk("rst_tap_ld", {31'd0, tap_ld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_fail", {30'd0, cal_done, cal_fail}, 32'd0);

        // Auto-calibration after reset: window 10..20 -> 15
        mask = 32'h001F_FC00;
        push(mask, 5'd15, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        cyc(2);
        chk("auto_start_busy", {31'd0, busy}, 32'd1);
        wait_scored("win_10_20");

        // Windows 2..5 and 20..27 -> 23
        mask = 32'h0FF0_003C;
        push(mask, 5'd23, 1'b1, 1'b0);
        pulse_start();
        wait_scored("two_windows");

        // Tie 3..6 vs 12..15 -> earlier kept, 4; START mid-sweep ignored
        mask = 32'h0000_F078;
        push(mask, 5'd4, 1'b1, 1'b0);
        pulse_start();
        cyc(500);
        pulse_start();
        wait_scored("tie");
        cyc(5);
        chk("start_while_busy_ignored", {31'd0, busy}, 32'd0);

        // No passing tap -> fail
        mask = 32'h0000_0000;
        push(mask, 5'd0, 1'b0, 1'b1);
        pulse_start();
        wait_scored("no_pass");

        // Window at the top end 28..31 -> 29
        mask = 32'hF000_0000;
        push(mask, 5'd29, 1'b1, 1'b0);
        pulse_start();
        wait_scored("top_window");

        // DLY_RDY drop in CHECK of tap 7; window 5..11 -> 8
        mask = 32'h0000_0FE0;
        ld7_count = 0;
        push(mask, 5'd8, 1'b1, 1'b0);
        pulse_start();
        wait_load(5'd7, ok);
        chk("tap7_loaded", {31'd0, ok}, 32'd1);
        cyc(30);
        dly_rdy = 1'b0;
        cyc(8);
        dly_rdy = 1'b1;
        wait_scored("rdy_drop");
        chk("tap7_reload_count", ld7_count, 32'd2);

        // Reset mid-sweep, then automatic restart with window 10..20
        mask = 32'h001F_FC00;
        pulse_start();
        wait_load(5'd5, ok);
        chk("tap5_loaded", {31'd0, ok}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tap_value", {27'd0, tap_value}, 32'd0);
        chk("midrst_ld_busy", {30'd0, tap_ld, busy}, 32'd0);
        chk("midrst_done_fail", {30'd0, cal_done, cal_fail}, 32'd0);
        push(mask, 5'd15, 1'b1, 1'b0);
        cyc(2);
        rst = 1'b0;
        wait_scored("after_reset");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
